// File: rtl/ram_dma_ci_param.sv
// Custom-instruction scratchpad RAM with a single-channel word-wise DMA engine.
// Optional completion interrupt port dma_irq is enabled by defining RAMDMA_IRQ_EN.
module ram_dma_ci_param #(
  parameter logic [7:0]  CUSTOM_ID = 8'd14,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned CNT_W     = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic        dma_req,
  output logic        dma_we,
  output logic [31:0] dma_addr,
  output logic [31:0] dma_wdata,
  input  logic        dma_ack,
  input  logic [31:0] dma_rdata
`ifdef RAMDMA_IRQ_EN
  ,
  output logic        dma_irq
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_REQ, S_GAP} state_t;

  state_t state_q, state_d;

  logic [31:0]       ram_q [DEPTH];
  logic [31:0]       busaddr_q;
  logic [ADDR_W-1:0] memaddr_q;
  logic [CNT_W-1:0]  bsize_q;
  logic [1:0]        ctrl_q;
  logic              err_q;
  logic              dir_q;
  logic [31:0]       bptr_q;
  logic [ADDR_W-1:0] mptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       wdata_q;
  logic              rd_pend_q;
  logic [31:0]       rd_data_q;

  logic              act, wr, busy, cpu_we, cpu_rd, cfg_we, xfer_go, ack_hit, dma_ram_we;
  logic [2:0]        sel;
  logic [ADDR_W-1:0] ci_addr;
  logic              unused_bits;

  assign act     = start && (ciN == CUSTOM_ID) && !reset;
  assign wr      = valueA[ADDR_W];
  assign sel     = valueA[ADDR_W+3:ADDR_W+1];
  assign ci_addr = valueA[ADDR_W-1:0];
  assign busy    = (state_q != S_IDLE);

  assign cpu_we  = act && wr && (sel == 3'd0);
  assign cpu_rd  = act && !wr && (sel == 3'd0);
  assign cfg_we  = act && wr && !busy && (sel >= 3'd1) && (sel <= 3'd4);
  assign xfer_go = cfg_we && (sel == 3'd4) && (valueB[1] ^ valueB[0]) && (bsize_q != '0);

  assign ack_hit    = (state_q == S_REQ) && dma_ack;
  assign dma_ram_we = ack_hit && !dir_q && !reset;

  assign unused_bits = ^valueA[31:ADDR_W+4];

  // A CPU write to the word the DMA is storing this cycle takes precedence.
  always_ff @(posedge clock) begin
    if (dma_ram_we && !(cpu_we && (ci_addr == mptr_q))) begin
      ram_q[mptr_q] <= dma_rdata;
    end
    if (cpu_we) begin
      ram_q[ci_addr] <= valueB;
    end
    rd_data_q <= ram_q[ci_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busaddr_q <= '0;
      memaddr_q <= '0;
      bsize_q   <= '0;
      ctrl_q    <= '0;
      err_q     <= 1'b0;
      dir_q     <= 1'b0;
      bptr_q    <= '0;
      mptr_q    <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= cpu_rd;
      if (cfg_we) begin
        case (sel)
          3'd1: busaddr_q <= valueB;
          3'd2: memaddr_q <= valueB[ADDR_W-1:0];
          3'd3: bsize_q   <= valueB[CNT_W-1:0];
          3'd4: begin
            ctrl_q <= valueB[1:0];
            if (valueB[1:0] == 2'b11) begin
              err_q <= 1'b1;
            end else if (valueB[1] ^ valueB[0]) begin
              err_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      if (xfer_go) begin
        bptr_q <= busaddr_q;
        mptr_q <= memaddr_q;
        cnt_q  <= bsize_q;
        dir_q  <= valueB[1];
      end
      if (state_q == S_FETCH) begin
        wdata_q <= ram_q[mptr_q];
      end
      if (ack_hit) begin
        mptr_q <= mptr_q + 1'b1;
        bptr_q <= bptr_q + 32'd4;
        cnt_q  <= cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer_go) state_d = valueB[1] ? S_FETCH : S_REQ;
      S_FETCH: state_d = S_REQ;
      S_REQ:   if (dma_ack) state_d = S_GAP;
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             state_d = dir_q ? S_FETCH : S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM reads answer one cycle late; every other CI access answers combinationally.
  always_comb begin
    done   = 1'b0;
    result = '0;
    if (rd_pend_q && !reset) begin
      done   = 1'b1;
      result = rd_data_q;
    end else if (act && !((sel == 3'd0) && !wr)) begin
      done = 1'b1;
      if (!wr) begin
        case (sel)
          3'd1:    result = busaddr_q;
          3'd2:    result = 32'(memaddr_q);
          3'd3:    result = 32'(bsize_q);
          3'd4:    result = 32'(ctrl_q);
          3'd5:    result = {30'b0, err_q, busy};
          default: result = '0;
        endcase
      end
    end
  end

  assign dma_req   = (state_q == S_REQ);
  assign dma_we    = dma_req && dir_q;
  assign dma_addr  = bptr_q;
  assign dma_wdata = wdata_q;

`ifdef RAMDMA_IRQ_EN
  logic irq_q;

  always_ff @(posedge clock) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= (state_q == S_GAP) && (cnt_q == '0);
  end

  assign dma_irq = irq_q;
`endif

endmodule

// File: tb/tb_ram_dma_ci_param.sv
// Scoreboard bench for ram_dma_ci_param: CI responses and bus transfers are queued
// at issue time and checked by independent monitors.
module tb_ram_dma_ci_param;
  localparam int unsigned AW = 9;

  logic        clock = 1'b0;
  logic        reset, start, dma_ack;
  logic [7:0]  ciN;
  logic [31:0] valueA, valueB, dma_rdata;
  logic        done, dma_req, dma_we;
  logic [31:0] result, dma_addr, dma_wdata;
`ifdef RAMDMA_IRQ_EN
  logic        dma_irq;
`endif

  always #5 clock = ~clock;

  ram_dma_ci_param #(.CUSTOM_ID(8'd14), .ADDR_W(AW), .CNT_W(10)) dut (
    .clock(clock), .reset(reset), .start(start), .ciN(ciN),
    .valueA(valueA), .valueB(valueB), .done(done), .result(result),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata)
`ifdef RAMDMA_IRQ_EN
    , .dma_irq(dma_irq)
`endif
  );

  typedef struct {logic [31:0] res; int unsigned cyc;} ci_exp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} bus_exp_t;
  ci_exp_t  ci_q[$];
  bus_exp_t bus_q[$];

  int          tests = 0, fails = 0;
  int unsigned cyc = 0;
  int          req_cycles = 0, irq_cnt = 0;
  logic        hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // CI response monitor
  initial forever begin
    ci_exp_t e;
    @(negedge clock);
    if (done === 1'b1) begin
      if (ci_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL ci_unexpected_done: result %h, expected no response", result);
      end else begin
        e = ci_q.pop_front();
        chk("ci_result", result, e.res);
        chk("ci_cycle", cyc, e.cyc);
      end
    end else if (result !== 32'd0) begin
      tests++; fails++;
      $display("FAIL ci_result_idle: got %h expected 00000000", result);
    end
  end

  // Bus slave: acknowledges in the second cycle of each request, returns the address as data.
  initial begin
    int wcnt;
    wcnt = 0; dma_ack = 1'b0; dma_rdata = '0;
    forever begin
      @(posedge clock); #2;
      if (dma_ack) begin
        dma_ack = 1'b0; wcnt = 0;
      end else if (dma_req && !hold) begin
        wcnt++;
        if (wcnt == 2) begin dma_ack = 1'b1; dma_rdata = dma_addr; end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Bus transaction monitor
  initial forever begin
    bus_exp_t e;
    @(negedge clock);
    if (dma_req === 1'b1) req_cycles++;
`ifdef RAMDMA_IRQ_EN
    if (dma_irq === 1'b1) irq_cnt++;
`endif
    if (dma_req === 1'b1 && dma_ack === 1'b1) begin
      if (bus_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL bus_unexpected: addr %h we %b, expected no transfer", dma_addr, dma_we);
      end else begin
        e = bus_q.pop_front();
        chk("bus_we", 32'(dma_we), 32'(e.we));
        chk("bus_addr", dma_addr, e.addr);
        if (e.we) chk("bus_wdata", dma_wdata, e.wdata);
      end
    end
  end

  // Caller is at posedge+1; leaves at posedge+1 two cycles later.
  task automatic ci(input logic [7:0] op, input logic [2:0] sel, input logic wr,
                    input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] exp);
    ci_exp_t e;
    if (op == 8'd14) begin
      e.res = exp;
      e.cyc = (sel == 3'd0 && !wr) ? cyc + 1 : cyc;
      ci_q.push_back(e);
    end
    valueA = (32'(sel) << (AW + 1)) | (32'(wr) << AW) | 32'(a);
    valueB = d; ciN = op; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic wr_reg(input logic [2:0] sel, input logic [31:0] d);
    ci(8'd14, sel, 1'b1, '0, d, 32'd0);
  endtask

  task automatic rd_reg(input logic [2:0] sel, input logic [31:0] exp);
    ci(8'd14, sel, 1'b0, '0, 32'd0, exp);
  endtask

  task automatic ram_wr(input logic [AW-1:0] a, input logic [31:0] d);
    ci(8'd14, 3'd0, 1'b1, a, d, 32'd0);
  endtask

  task automatic ram_rd(input logic [AW-1:0] a, input logic [31:0] exp);
    ci(8'd14, 3'd0, 1'b0, a, 32'd0, exp);
  endtask

  task automatic wait_bus_done();
    for (int i = 0; i < 400 && bus_q.size() != 0; i++) @(posedge clock);
    if (bus_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL bus_timeout: %0d transfers outstanding, expected 0", bus_q.size());
      bus_q.delete();
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic push_bus(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus_exp_t e;
    e.we = we; e.addr = a; e.wdata = d;
    bus_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    reset = 1'b1; start = 1'b0; ciN = '0; valueA = '0; valueB = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_req", 32'(dma_req), 32'd0);
    chk("rst_we", 32'(dma_we), 32'd0);
    chk("rst_addr", dma_addr, 32'd0);
    chk("rst_wdata", dma_wdata, 32'd0);
`ifdef RAMDMA_IRQ_EN
    chk("rst_irq", 32'(dma_irq), 32'd0);
`endif
    reset = 1'b0;
    @(posedge clock); #1;
    rd_reg(3'd5, 32'd0);

    // RAM fill and readback
    for (int a = 0; a < 512; a++) ram_wr(AW'(a), 32'(a * 3));
    for (int a = 0; a < 512; a++) ram_rd(AW'(a), 32'(a * 3));

    // Foreign opcode is ignored
    valueA = (32'd1 << AW) | 32'd7; valueB = 32'hDEAD; ciN = 8'd13; start = 1'b1;
    #1;
    chk("foreign_done", 32'(done), 32'd0);
    chk("foreign_result", result, 32'd0);
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    ram_rd(AW'(7), 32'd21);

    // bus->mem across the RAM wrap
    wr_reg(3'd1, 32'h1000);
    wr_reg(3'd2, 32'd510);
    wr_reg(3'd3, 32'd4);
    for (int i = 0; i < 4; i++) push_bus(1'b0, 32'h1000 + 32'(4 * i), 32'd0);
    wr_reg(3'd4, 32'd1);
    rd_reg(3'd5, 32'd1);
    wr_reg(3'd1, 32'hFFFF_0000);
    wait_bus_done();
    rd_reg(3'd5, 32'd0);
    rd_reg(3'd1, 32'h1000);
    rd_reg(3'd2, 32'd510);
    ram_rd(AW'(510), 32'h1000);
    ram_rd(AW'(511), 32'h1004);
    ram_rd(AW'(0), 32'h1008);
    ram_rd(AW'(1), 32'h100C);

    // mem->bus
    wr_reg(3'd1, 32'h2000);
    wr_reg(3'd2, 32'd5);
    wr_reg(3'd3, 32'd3);
    for (int i = 0; i < 3; i++) push_bus(1'b1, 32'h2000 + 32'(4 * i), 32'(15 + 3 * i));
    wr_reg(3'd4, 32'd2);
    wait_bus_done();
    rd_reg(3'd5, 32'd0);

    // Reset while a request is outstanding
    hold = 1'b1;
    wr_reg(3'd1, 32'h5000);
    wr_reg(3'd2, 32'd50);
    wr_reg(3'd3, 32'd2);
    wr_reg(3'd4, 32'd1);
    for (int i = 0; i < 50 && dma_req !== 1'b1; i++) @(negedge clock);
    chk("req_before_reset", 32'(dma_req), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("req_after_reset", 32'(dma_req), 32'd0);
    hold = 1'b0;
    rd_reg(3'd5, 32'd0);
    rd_reg(3'd1, 32'd0);
    rd_reg(3'd3, 32'd0);
    ram_rd(AW'(1), 32'h100C);
    ram_rd(AW'(50), 32'd150);
    wr_reg(3'd1, 32'h3000);
    wr_reg(3'd2, 32'd0);
    wr_reg(3'd3, 32'd1);
    push_bus(1'b1, 32'h3000, 32'h1008);
    wr_reg(3'd4, 32'd2);
    wait_bus_done();
    rd_reg(3'd5, 32'd0);

    // Zero-length start and illegal control
    r0 = req_cycles;
    wr_reg(3'd3, 32'd0);
    wr_reg(3'd4, 32'd1);
    repeat (10) @(posedge clock);
    #1;
    chk("zero_len_no_req", 32'(req_cycles), 32'(r0));
    rd_reg(3'd5, 32'd0);
    wr_reg(3'd4, 32'd3);
    rd_reg(3'd4, 32'd3);
    rd_reg(3'd5, 32'd2);
    chk("ctrl11_no_req", 32'(req_cycles), 32'(r0));
    wr_reg(3'd1, 32'h4000);
    wr_reg(3'd2, 32'd100);
    wr_reg(3'd3, 32'd1);
    push_bus(1'b0, 32'h4000, 32'd0);
    wr_reg(3'd4, 32'd1);
    wait_bus_done();
    rd_reg(3'd5, 32'd0);
    ram_rd(AW'(100), 32'h4000);

    repeat (3) @(posedge clock);
    #1;
    chk("ci_queue_empty", 32'(ci_q.size()), 32'd0);
    chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
`ifdef RAMDMA_IRQ_EN
    chk("irq_count", 32'(irq_cnt), 32'd4);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
